vector_lsu_sequencer: RTL

- Sequences one vector memory operation at a time into per-element 64-bit accesses on a single shared scalar memory port.
- Sits between the vector issue stage and the L1 data port. Replaces the all-lanes-in-one-cycle behavioural LSU path for bring-up with real memory.
- Supports strided addressing, vector length (VL) masking and a bounded number of outstanding loads.
- Assembles in-order load responses into one 512-bit result.

---
 rtl/vector_lsu_sequencer.sv | 89 ++++++++
 1 files changed

// File: rtl/vector_lsu_sequencer.sv
// vector_lsu_sequencer: splits one vector load/store into strided 64-bit accesses on a scalar port and assembles in-order load data
// Ports: op_* accepts an operation in IDLE; mem_req_* issues one element per handshake;
// mem_resp_* returns load data in request order; done_* pulses for one cycle in DONE;
// load_data_o holds the assembled result until the next accept; busy_o is high outside IDLE.
module vector_lsu_sequencer #(
  parameter int NUM_LANES = 8,
  parameter int MAX_OUT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op_valid_i,
  output logic                    op_ready_o,
  input  logic                    op_is_store_i,
  input  logic [63:0]             op_base_i,
  input  logic [63:0]             op_stride_i,
  input  logic [3:0]              op_vl_i,
  input  logic [NUM_LANES*64-1:0] op_wdata_i,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [63:0]             mem_req_addr_o,
  output logic                    mem_req_we_o,
  output logic [63:0]             mem_req_wdata_o,
  input  logic                    mem_resp_valid_i,
  input  logic [63:0]             mem_resp_data_i,
  output logic                    done_valid_o,
  output logic                    done_is_store_o,
  output logic [NUM_LANES*64-1:0] load_data_o,
  output logic                    busy_o
);
  localparam int LW = NUM_LANES * 64;
  localparam int OW = $clog2(MAX_OUT) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic is_store;
  logic [63:0] base, stride;
  logic [3:0] vl, issue_cnt, resp_cnt;
  logic [OW-1:0] out_cnt;
  logic [LW-1:0] wdata, load_data;
  logic accept, req_fire, resp_fire, fin;
  always_comb begin
    accept = op_valid_i & (state == IDLE);
    mem_req_valid_o = (state == RUN) & (issue_cnt < vl) & (is_store | (out_cnt < OW'(MAX_OUT)));
    mem_req_addr_o = base + stride * 64'(issue_cnt);
    mem_req_we_o = (state == RUN) & is_store;
    mem_req_wdata_o = mem_req_we_o ? 64'(wdata >> {issue_cnt, 6'd0}) : '0;
    req_fire = mem_req_valid_o & mem_req_ready_i;
    // responses only count while loads are genuinely outstanding; late or stray beats fall through
    resp_fire = (state == RUN) & ~is_store & mem_resp_valid_i & (out_cnt != '0);
    fin = is_store ? (issue_cnt + 4'(req_fire) == vl) : (resp_cnt + 4'(resp_fire) == vl);
    op_ready_o = state == IDLE;
    busy_o = state != IDLE;
    done_valid_o = state == DONE;
    done_is_store_o = (state == DONE) & is_store;
    load_data_o = load_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      is_store <= 1'b0;
      base <= '0;
      stride <= '0;
      vl <= '0;
      wdata <= '0;
      issue_cnt <= '0;
      resp_cnt <= '0;
      out_cnt <= '0;
      load_data <= '0;
    end else if (accept) begin
      is_store <= op_is_store_i;
      base <= op_base_i;
      stride <= op_stride_i;
      vl <= op_vl_i;
      wdata <= op_wdata_i;
      issue_cnt <= '0;
      resp_cnt <= '0;
      out_cnt <= '0;
      load_data <= '0;
      state <= (op_vl_i == '0) ? DONE : RUN;
    end else if (state == DONE) begin
      state <= IDLE;
    end else if (state == RUN) begin
      issue_cnt <= issue_cnt + 4'(req_fire);
      resp_cnt <= resp_cnt + 4'(resp_fire);
      out_cnt <= out_cnt + OW'(req_fire & ~is_store) - OW'(resp_fire);
      if (resp_fire) load_data <= load_data | (LW'(mem_resp_data_i) << {resp_cnt, 6'd0});
      if (fin) state <= DONE;
    end
  end
endmodule
